// File: rtl/cordic_phase_gen_pkg.sv
// Shared definitions for the CORDIC phase feeder and the downstream sign-reconstruction stage.
package cordic_phase_gen_pkg;

    localparam int PHASE_W_DEF = 10;
    localparam int ANGLE_W_DEF = 8;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Bit q of each map is the sign flag for quadrant q (sin < 0 in q2/q3, cos < 0 in q1/q2).
    localparam logic [3:0] NEG_SIN_BY_QUAD = 4'b1100;
    localparam logic [3:0] NEG_COS_BY_QUAD = 4'b0110;

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Folds a full-circle phase into a first-quadrant angle plus sin/cos sign flags.
module cordic_quadrant_fold
    import cordic_phase_gen_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ANGLE_W = ANGLE_W_DEF
) (
    input  logic [PHASE_W-1:0] phase,
    output logic [ANGLE_W-1:0] angle,
    output logic               neg_sin,
    output logic               neg_cos
);

    logic [1:0]         quad;
    logic [ANGLE_W-1:0] frac;

    assign quad = phase[PHASE_W-1:PHASE_W-2];
    assign frac = phase[ANGLE_W-1:0];

    // Odd quadrants run backwards; the one's complement mirrors with a half-LSB bias.
    assign angle   = quad[0] ? ~frac : frac;
    assign neg_sin = NEG_SIN_BY_QUAD[quad];
    assign neg_cos = NEG_COS_BY_QUAD[quad];

endmodule

// File: rtl/cordic_phase_gen.sv
// NCO phase accumulator issuing folded CORDIC angles as valid/ready bursts.
module cordic_phase_gen
    import cordic_phase_gen_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ANGLE_W = ANGLE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [PHASE_W-1:0] phase_init,
    input  logic [PHASE_W-1:0] ftw,
    input  logic [CNT_W-1:0]   burst_len,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ANGLE_W-1:0] out_angle,
    output logic               neg_sin,
    output logic               neg_cos,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] ftw_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   count_q;
    logic               stop_seen_q;
    logic               accept;
    logic               last_beat;

    assign accept    = (state_q == ST_RUN) && out_ready;
    assign last_beat = (len_q != '0) && ((count_q + CNT_W'(1)) == len_q);

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (accept && (last_beat || stop_seen_q || stop)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= '0;
            ftw_q       <= '0;
            len_q       <= '0;
            count_q     <= '0;
            stop_seen_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        phase_q     <= phase_init;
                        ftw_q       <= ftw;
                        len_q       <= burst_len;
                        count_q     <= '0;
                        stop_seen_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop) stop_seen_q <= 1'b1;
                    if (accept) begin
                        phase_q <= phase_q + ftw_q;
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                ST_DONE: stop_seen_q <= 1'b0;
                default: stop_seen_q <= 1'b0;
            endcase
        end
    end

    // Outputs decode registered state only; nothing flows combinationally from inputs.
    assign out_valid = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);

    cordic_quadrant_fold #(
        .PHASE_W (PHASE_W),
        .ANGLE_W (ANGLE_W)
    ) u_fold (
        .phase   (phase_q),
        .angle   (out_angle),
        .neg_sin (neg_sin),
        .neg_cos (neg_cos)
    );

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Randomized bench for cordic_phase_gen against an arithmetic quadrant/NCO model.
module tb_cordic_phase_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [9:0]  phase_init = '0;
    logic [9:0]  ftw = '0;
    logic [15:0] burst_len = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_angle;
    logic        neg_sin;
    logic        neg_cos;
    logic        busy;
    logic        done;

    int tests_run = 0;
    int failed = 0;

    always #5 clk = ~clk;

    cordic_phase_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .phase_init (phase_init),
        .ftw        (ftw),
        .burst_len  (burst_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_angle  (out_angle),
        .neg_sin    (neg_sin),
        .neg_cos    (neg_cos),
        .busy       (busy),
        .done       (done)
    );

    // Model: 1024 codes per circle, 256 per quadrant; returns {angle, neg_sin, neg_cos}.
    function automatic logic [9:0] fold_ref(input int ph);
        int p, quad, a, ang;
        logic ns, nc;
        p    = ph % 1024;
        quad = p / 256;
        a    = p % 256;
        ang  = (quad == 1 || quad == 3) ? 255 - a : a;
        ns   = (quad >= 2);
        nc   = (quad == 1 || quad == 2);
        return {ang[7:0], ns, nc};
    endfunction

    function automatic int beat_phase(input int init, input int f, input int k);
        return (init + k * f) % 1024;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int init, input int f, input int len);
        start      = 1'b1;
        phase_init = init[9:0];
        ftw        = f[9:0];
        burst_len  = len[15:0];
        tick();
        start      = 1'b0;
        phase_init = 10'($urandom);
        ftw        = 10'($urandom);
        burst_len  = 16'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            start      = 1'($urandom);
            stop       = 1'($urandom);
            out_ready  = 1'($urandom);
            phase_init = 10'($urandom);
            ftw        = 10'($urandom);
            burst_len  = 16'($urandom);
            tick();
            tests_run++;
            if ({out_valid, out_angle, neg_sin, neg_cos, busy, done} !== 13'd0) begin
                failed++;
                $display("FAIL reset_outputs cycle %0d: got valid=%b angle=%0d ns=%b nc=%b busy=%b done=%b, want all 0",
                         c, out_valid, out_angle, neg_sin, neg_cos, busy, done);
            end
        end
        start = 1'b0;
        stop = 1'b0;
        out_ready = 1'b0;
        reset_n = 1'b1;
        tick();
        tests_run++;
        if ({out_valid, busy, done} !== 3'b000) begin
            failed++;
            $display("FAIL reset_release_idle: got valid=%b busy=%b done=%b, want 000", out_valid, busy, done);
        end
    endtask

    // Runs one burst with random READY and junk START/config activity, checking every beat and the DONE tail.
    task automatic test_burst(input string name, input int init, input int f, input int len, input int ready_pct);
        int k = 0;
        int cycles = 0;
        logic rdy;
        logic [9:0] exp;
        do_start(init, f, len);
        while (k < len && cycles < 2000) begin
            exp = fold_ref(beat_phase(init, f, k));
            tests_run++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
                {out_angle, neg_sin, neg_cos} !== exp) begin
                failed++;
                $display("FAIL %s beat %0d: got valid=%b busy=%b done=%b angle=%0d ns=%b nc=%b, want 1 1 0 angle=%0d ns=%b nc=%b",
                         name, k, out_valid, busy, done, out_angle, neg_sin, neg_cos, exp[9:2], exp[1], exp[0]);
            end
            rdy        = ($urandom_range(99) < ready_pct);
            out_ready  = rdy;
            start      = ($urandom_range(3) == 0);
            phase_init = 10'($urandom);
            ftw        = 10'($urandom);
            tick();
            if (rdy) k++;
            cycles++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (k != len) begin
            failed++;
            $display("FAIL %s timeout: accepted %0d beats, want %0d", name, k, len);
        end
        tests_run++;
        if ({out_valid, busy, done} !== 3'b001) begin
            failed++;
            $display("FAIL %s done_pulse: got valid=%b busy=%b done=%b, want 001", name, out_valid, busy, done);
        end
        tick();
        tests_run++;
        if ({out_valid, busy, done} !== 3'b000) begin
            failed++;
            $display("FAIL %s back_to_idle: got valid=%b busy=%b done=%b, want 000", name, out_valid, busy, done);
        end
    endtask

    task automatic test_stall();
        int init = 10'($urandom);
        logic [9:0] exp0 = fold_ref(beat_phase(init, 64, 0));
        logic [9:0] exp1 = fold_ref(beat_phase(init, 64, 1));
        do_start(init, 64, 2);
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if (out_valid !== 1'b1 || {out_angle, neg_sin, neg_cos} !== exp0) begin
                failed++;
                $display("FAIL stall_hold cycle %0d: got valid=%b fold=%h, want 1 fold=%h", c, out_valid,
                         {out_angle, neg_sin, neg_cos}, exp0);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || {out_angle, neg_sin, neg_cos} !== exp1) begin
            failed++;
            $display("FAIL stall_advance: got valid=%b fold=%h, want 1 fold=%h", out_valid,
                     {out_angle, neg_sin, neg_cos}, exp1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (done !== 1'b1) begin
            failed++;
            $display("FAIL stall_done: got done=%b, want 1", done);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_start(10'($urandom), 64, 8);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_angle, neg_sin, neg_cos, busy, done} !== 13'd0) begin
            failed++;
            $display("FAIL midreset_async: got valid=%b angle=%0d ns=%b nc=%b busy=%b done=%b, want all 0",
                     out_valid, out_angle, neg_sin, neg_cos, busy, done);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            tests_run++;
            if ({out_valid, busy, done} !== 3'b000) begin
                failed++;
                $display("FAIL midreset_no_done cycle %0d: got valid=%b busy=%b done=%b, want 000",
                         c, out_valid, busy, done);
            end
        end
    endtask

    task automatic test_stop_stalled();
        int init = 10'($urandom);
        int f = 10'($urandom);
        logic [9:0] exp;
        do_start(init, f, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        out_ready = 1'b0;
        exp = fold_ref(beat_phase(init, f, 3));
        start = 1'b1;
        phase_init = 10'(init + 300);
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if ({out_valid, busy, done} !== 3'b110 || {out_angle, neg_sin, neg_cos} !== exp) begin
                failed++;
                $display("FAIL stop_pending cycle %0d: got valid=%b busy=%b done=%b fold=%h, want 110 fold=%h",
                         c, out_valid, busy, done, {out_angle, neg_sin, neg_cos}, exp);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if ({out_valid, busy, done} !== 3'b001) begin
            failed++;
            $display("FAIL stop_done: got valid=%b busy=%b done=%b, want 001", out_valid, busy, done);
        end
        tick();
        tests_run++;
        if ({out_valid, busy, done} !== 3'b000) begin
            failed++;
            $display("FAIL stop_idle: got valid=%b busy=%b done=%b, want 000", out_valid, busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_burst("constant_210", 210, 0, 3, 100);
        test_burst("quad1_350", 350, 0, 1, 100);
        test_burst("wrap_1000", 1000, 50, 2, 100);
        test_stall();
        test_reset_mid_burst();
        test_stop_stalled();
        for (int i = 0; i < 6; i++)
            test_burst("random", $urandom_range(1023), $urandom_range(1023), $urandom_range(1, 8), 60);
        test_burst("back_to_back", $urandom_range(1023), $urandom_range(1023), 5, 100);
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
